// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_pkg : opcodes, latencies and helpers shared by the HI/LO unit
// Revision     : 1.0
// ============================================================================
package mult_div_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;
  localparam int MD_CNT_W      = 4;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic [MD_CNT_W-1:0] md_latency(input md_op_e op);
    return md_is_div(op) ? MD_CNT_W'(MD_DIV_CYCLES) : MD_CNT_W'(MD_MUL_CYCLES);
  endfunction

endpackage : mult_div_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// md_arith : combinational multiply/divide datapath producing {hi, lo}
// Revision : 1.0
// ============================================================================
module md_arith
  import mult_div_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic        is_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    is_signed = md_is_signed(op);

    // Low 64 bits of an extended product are correct for both signednesses
    ext_a   = {{32{is_signed & a[31]}}, a};
    ext_b   = {{32{is_signed & b[31]}}, b};
    product = ext_a * ext_b;

    // Magnitude division gives truncation toward zero and makes the
    // 0x80000000 / -1 case fall out as 0x80000000 with no special path
    a_neg    = is_signed & a[31];
    b_neg    = is_signed & b[31];
    a_mag    = a_neg ? (32'd0 - a) : a;
    b_mag    = b_neg ? (32'd0 - b) : b;
    div_zero = md_is_div(op) && (b == 32'd0);
    divisor  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag    = a_mag / divisor;
    r_mag    = a_mag % divisor;
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    if (md_is_div(op)) begin
      hi = rem;
      lo = quot;
    end else begin
      hi = product[63:32];
      lo = product[31:0];
    end
  end

endmodule : md_arith
`default_nettype wire

// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
// mult_div : fixed-latency HI/LO multiply/divide unit with MTHI/MTLO writes
// Revision : 1.0
// ============================================================================
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_E,
  input  logic [1:0]  MDControl_E,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDWrite_E,
  input  logic        HiLo_E,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  md_op_e              op_q, op_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;

  logic [31:0]         res_hi;
  logic [31:0]         res_lo;
  logic                res_div_zero;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi       (res_hi),
    .lo       (res_lo),
    .div_zero (res_div_zero)
  );

  assign Busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (cnt_q != '0) begin
      // Result lands on the same edge that Busy falls
      cnt_d = cnt_q - 1'b1;
      if ((cnt_q == MD_CNT_W'(1)) && !res_div_zero) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end else if (Start_E) begin
      a_d   = A;
      b_d   = B;
      op_d  = md_op_e'(MDControl_E);
      cnt_d = md_latency(md_op_e'(MDControl_E));
    end else if (MDWrite_E) begin
      if (HiLo_E) begin
        hi_d = A;
      end else begin
        lo_d = A;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_MULT;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule : mult_div
`default_nettype wire

// File: tb/tb_mult_div.sv
`default_nettype none
// ============================================================================
// tb_mult_div : directed vectors against a completion-time model of HI/LO
// Revision    : 1.0
// ============================================================================
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start_E = 1'b0;
  logic [1:0]  MDControl_E = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        MDWrite_E = 1'b0;
  logic        HiLo_E = 1'b0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_pass = 0;
  int n_total = 0;

  mult_div dut (
    .clk         (clk),
    .reset       (reset),
    .Start_E     (Start_E),
    .MDControl_E (MDControl_E),
    .A           (A),
    .B           (B),
    .MDWrite_E   (MDWrite_E),
    .HiLo_E      (HiLo_E),
    .Busy        (Busy),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Plain-arithmetic reference: {hi, lo}
  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: if (sb != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      default: if (ub != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        r  = {ur[31:0], uq[31:0]};
      end
    endcase
    return r;
  endfunction

  // Model tracks the edge index at which the pending result completes
  int          edge_no = 0;
  int          done_at = 0;
  bit          pending = 1'b0;
  logic [63:0] p_res = 64'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_at <= 0;
      pending <= 1'b0;
      m_hi    <= 32'd0;
      m_lo    <= 32'd0;
    end else begin
      edge_no <= edge_no + 1;
      if (pending && (edge_no + 1 == done_at)) begin
        m_hi <= p_res[63:32];
        m_lo <= p_res[31:0];
      end
      if (edge_no >= done_at) begin
        if (Start_E) begin
          done_at <= edge_no + 1 + (MDControl_E[1] ? 10 : 5);
          p_res   <= model_result(MDControl_E, A, B);
          pending <= !(MDControl_E[1] && (B == 32'd0));
        end else if (MDWrite_E) begin
          if (HiLo_E) m_hi <= A;
          else        m_lo <= A;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("model Busy", {31'd0, Busy}, {31'd0, (edge_no < done_at)});
      check("model HI", HI, m_hi);
      check("model LO", LO, m_lo);
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit with_write,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int lat;
    lat = op[1] ? 10 : 5;
    @(negedge clk);
    Start_E     = 1'b1;
    MDControl_E = op;
    A           = a;
    B           = b;
    MDWrite_E   = with_write;
    HiLo_E      = 1'b1;
    @(negedge clk);
    Start_E     = 1'b0;
    MDWrite_E   = 1'b0;
    A           = $urandom;
    B           = $urandom;
    MDControl_E = 2'($urandom);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, n, lat);
    check({name, " HI"}, HI, exp_hi);
    check({name, " LO"}, LO, exp_lo);
  endtask

  task automatic move_to(input bit to_hi, input logic [31:0] v);
    @(negedge clk);
    MDWrite_E = 1'b1;
    HiLo_E    = to_hi;
    A         = v;
    @(negedge clk);
    MDWrite_E = 1'b0;
    if (to_hi) check("MTHI", HI, v);
    else       check("MTLO", LO, v);
  endtask

  initial begin
    #7;
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset Busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("MULT",        2'b00, 32'hFFFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("MULTU",       2'b01, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE);
    run_op("DIV -7/2",    2'b10, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("DIV ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);
    run_op("DIV 7/-2",    2'b10, 32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD);
    run_op("DIVU 100/7",  2'b11, 32'd100,      32'd7,        1'b0, 32'd2,        32'd14);
    run_op("MULT -3*5",   2'b00, 32'hFFFFFFFD, 32'd5,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);

    move_to(1'b1, 32'h11);
    move_to(1'b0, 32'h22);
    run_op("DIVU by 0",   2'b11, 32'd5,        32'd0,        1'b0, 32'h11,       32'h22);
    run_op("Start+write", 2'b01, 32'd6,        32'd7,        1'b1, 32'd0,        32'd42);

    move_to(1'b1, 32'hAAAA);
    move_to(1'b0, 32'h5555);

    // DIV in flight; MTLO and a second Start are both ignored, then reset aborts it
    @(negedge clk);
    Start_E = 1'b1; MDControl_E = 2'b10; A = 32'd100; B = 32'd3;
    @(negedge clk);
    Start_E = 1'b0; MDWrite_E = 1'b1; HiLo_E = 1'b0; A = 32'h1234;
    @(negedge clk);
    MDWrite_E = 1'b0; Start_E = 1'b1; MDControl_E = 2'b00; A = 32'd2; B = 32'd2;
    @(negedge clk);
    Start_E = 1'b0;
    check("busy-write ignored", LO, 32'h5555);
    check("in-flight Busy", {31'd0, Busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async reset HI", HI, 32'd0);
    check("async reset LO", LO, 32'd0);
    check("async reset Busy", {31'd0, Busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post-abort HI", HI, 32'd0);
    check("post-abort LO", LO, 32'd0);

    run_op("MULTU after reset", 2'b01, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mult_div
`default_nettype wire
